// File: rtl/data_mem_responder.sv
// data_mem_responder: word-wide data memory for the MIPS datapath.
// It checks each load/store request when it is accepted. Valid requests
// wait WAIT_STATES extra cycles and then touch the RAM. Rejected requests
// retire immediately with error set. busy/done let the datapath stall.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  // A request is rejected if both strobes are set, if the address is not
  // word aligned, or if it lies beyond the end of the RAM.
  function automatic logic req_rejected(input logic        rd,
                                        input logic        wr,
                                        input logic [31:0] addr);
    logic [31:0] upper;
    upper = addr >> (ADDR_WIDTH + 2);
    return (rd & wr) | (addr[1:0] != 2'b00) | (upper != 32'd0);
  endfunction

  state_t                  state_r, state_s;
  logic [3:0]              cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0]   idx_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    is_load_r;
  logic [DATA_WIDTH-1:0]   read_data_r;
  logic                    busy_r, done_r, error_r;
  logic                    busy_s, done_s, error_s;
  logic                    accept_s;
  logic                    access_s;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  // Next-state, wait counter and access strobe decode.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    access_s = 1'b0;
    error_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (memRead | memWrite) begin
          accept_s = 1'b1;
          if (req_rejected(memRead, memWrite, address)) begin
            state_s = DONE;
            cnt_s   = 4'd0;
            error_s = 1'b1;
          end else begin
            state_s = WAIT;
            cnt_s   = WAIT_INIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          access_s = 1'b1;
          state_s  = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
    busy_s = (state_s == WAIT);
    done_s = (state_s == DONE);
  end

  // State, request latch, load result and status outputs.
  // The status outputs are registered from the next state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      idx_r       <= '0;
      wdata_r     <= '0;
      is_load_r   <= 1'b0;
      read_data_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      error_r <= error_s;
      if (accept_s) begin
        idx_r     <= address[ADDR_WIDTH+1:2];
        wdata_r   <= writeData;
        is_load_r <= memRead;
      end
      if (access_s && is_load_r) begin
        read_data_r <= mem[idx_r];
      end
    end
  end

  // Store port of the RAM. It is not cleared by reset.
  // Reset forces IDLE, so a pending store can never fire.
  always_ff @(posedge clk) begin
    if (access_s && !is_load_r) begin
      mem[idx_r] <= wdata_r;
    end
  end

  assign readData = read_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder.
// It uses three instances, with W=2, W=0 and W=3.
// Expected results are pushed to a scoreboard queue when a request is
// driven, and popped and compared when the request retires.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];

  logic [31:0] rdata0, rdata1, rdata2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        err0, err1, err2;

  int tests = 0;
  int fails = 0;
  int wst [3] = '{2, 0, 3};

  typedef struct packed {
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  typedef struct {
    int          idx;
    logic        rej;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_mem [3][256];
  logic [31:0] model_rd  [3];

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(2)) u0 (
    .clk(clk), .rstN(rst_n[0]), .memRead(rd[0]), .memWrite(wr[0]),
    .address(addr[0]), .writeData(wdata[0]), .readData(rdata0),
    .busy(busy0), .done(done0), .error(err0));

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) u1 (
    .clk(clk), .rstN(rst_n[1]), .memRead(rd[1]), .memWrite(wr[1]),
    .address(addr[1]), .writeData(wdata[1]), .readData(rdata1),
    .busy(busy1), .done(done1), .error(err1));

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(3)) u2 (
    .clk(clk), .rstN(rst_n[2]), .memRead(rd[2]), .memWrite(wr[2]),
    .address(addr[2]), .writeData(wdata[2]), .readData(rdata2),
    .busy(busy2), .done(done2), .error(err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obs(input int i);
    case (i)
      0:       return {rdata0, busy0, done0, err0};
      1:       return {rdata1, busy1, done1, err1};
      default: return {rdata2, busy2, done2, err2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Issue one request on instance i and follow it to retirement.
  // The task returns in the done cycle, so the next call is back-to-back.
  task automatic req(input int i, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input string tag);
    exp_t e;
    obs_t o;
    int   cyc;
    e.idx = i;
    e.rej = (r & w) | (a[1:0] != 2'b00) | (a[31:10] != 22'd0);
    if (!e.rej && r) model_rd[i] = model_mem[i][a[9:2]];
    if (!e.rej && w) model_mem[i][a[9:2]] = d;
    e.data = model_rd[i];
    sb.push_back(e);
    rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clk); #1;
    rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = $urandom; wdata[i] = $urandom;
    cyc = 0;
    o = obs(i);
    while (o.busy && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
      o = obs(i);
    end
    e = sb.pop_front();
    chk({tag, " busy_cycles"}, cyc, e.rej ? 32'd0 : 32'(wst[e.idx] + 1));
    chk({tag, " done"},  {31'd0, o.done}, 32'd1);
    chk({tag, " error"}, {31'd0, o.err}, {31'd0, e.rej});
    chk({tag, " readData"}, o.rdata, e.data);
  endtask

  initial begin
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
      addr[i] = 32'd0; wdata[i] = 32'd0; model_rd[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      chk($sformatf("reset%0d outputs", i), {o.rdata[28:0], o.busy, o.done, o.err}, 32'd0);
      chk($sformatf("reset%0d rdata_hi", i), {29'd0, o.rdata[31:29]}, 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(posedge clk); #1;

    // W=2: store then load
    req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "w2_store");
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, "w2_load");
    // misaligned load leaves readData alone
    req(0, 1'b1, 1'b0, 32'h13, 32'h0, "misaligned");
    @(posedge clk); #1;
    o = obs(0);
    chk("post_reject done", {31'd0, o.done}, 32'd0);
    chk("post_reject error", {31'd0, o.err}, 32'd0);
    // both strobes high
    req(0, 1'b0, 1'b1, 32'h8, 32'h77, "pre_both_store");
    req(0, 1'b1, 1'b1, 32'h8, 32'hFFFF, "both_strobes");
    req(0, 1'b1, 1'b0, 32'h8, 32'h0, "both_reload");
    // out of range
    req(0, 1'b0, 1'b1, 32'h0, 32'h0BAD0000, "pre_oor_store");
    req(0, 1'b0, 1'b1, 32'h400, 32'h12345678, "out_of_range");
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, "oor_reload");
    @(posedge clk); #1;

    // W=0: back-to-back
    req(1, 1'b0, 1'b1, 32'h0, 32'h1111, "b2b_store0");
    req(1, 1'b0, 1'b1, 32'h4, 32'h2222, "b2b_store4");
    req(1, 1'b1, 1'b0, 32'h0, 32'h0, "b2b_load0");
    req(1, 1'b1, 1'b0, 32'h4, 32'h0, "b2b_load4");
    @(posedge clk); #1;

    // W=3: reset in the middle of a store
    req(2, 1'b0, 1'b1, 32'h20, 32'h5555, "w3_store");
    req(2, 1'b1, 1'b0, 32'h20, 32'h0, "w3_load");
    @(posedge clk); #1;
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hAAAA;
    @(posedge clk); #1;
    wr[2] = 1'b0;
    @(posedge clk); #1;
    o = obs(2);
    chk("mid_store busy", {31'd0, o.busy}, 32'd1);
    rst_n[2] = 1'b0;
    #1;
    o = obs(2);
    chk("rst busy", {31'd0, o.busy}, 32'd0);
    chk("rst done", {31'd0, o.done}, 32'd0);
    chk("rst error", {31'd0, o.err}, 32'd0);
    chk("rst readData", o.rdata, 32'd0);
    model_rd[2] = 32'd0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    req(2, 1'b1, 1'b0, 32'h20, 32'h0, "post_rst_load");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
